// File: rtl/l1_llc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l1_llc_arbiter
// Brief    : Serialises L1-I refill, L1-D refill and L1-D writeback onto one
//            LLC read/write port pair; writeback has strict priority.
//            Define L1_ARB_RR_EN for round-robin I/D reads (else D over I).
// Revision : 1.0 - initial release
// ============================================================================
module l1_llc_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] I_R_ADDR,
  input  logic                  I_R_ADDR_VALID,
  output logic [LINE_WIDTH-1:0] I_R_DATA,
  output logic                  I_R_DATA_VALID,
  input  logic [ADDR_WIDTH-1:0] D_R_ADDR,
  input  logic                  D_R_ADDR_VALID,
  output logic [LINE_WIDTH-1:0] D_R_DATA,
  output logic                  D_R_DATA_VALID,
  input  logic                  D_W_VALID,
  input  logic [ADDR_WIDTH-1:0] D_W_ADDR,
  input  logic [LINE_WIDTH-1:0] D_W_DATA,
  output logic                  D_W_READY,
  output logic                  D_W_COMPLETE,
  output logic [ADDR_WIDTH-1:0] M_R_ADDR,
  output logic                  M_R_ADDR_VALID,
  input  logic [LINE_WIDTH-1:0] M_R_DATA,
  input  logic                  M_R_DATA_VALID,
  output logic                  M_W_VALID,
  output logic [ADDR_WIDTH-1:0] M_W_ADDR,
  output logic [LINE_WIDTH-1:0] M_W_DATA,
  input  logic                  M_W_READY,
  input  logic                  M_W_COMPLETE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_I    = 3'd1,
    S_RD_D    = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [LINE_WIDTH-1:0] r_wr_data;
  logic                  r_m_r_valid;
  logic                  r_m_w_valid;
  logic                  w_grant_i;
  logic                  w_grant_d;

`ifdef L1_ARB_RR_EN
  // 1 = the most recent read grant went to L1-I
  logic r_last_i;

  always_comb begin
    w_grant_i = I_R_ADDR_VALID && (!D_R_ADDR_VALID || !r_last_i);
    w_grant_d = D_R_ADDR_VALID && !w_grant_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_i <= 1'b0;
    end else if (r_state == S_IDLE && !D_W_VALID && (w_grant_i || w_grant_d)) begin
      r_last_i <= w_grant_i;
    end
  end
`else
  always_comb begin
    w_grant_d = D_R_ADDR_VALID;
    w_grant_i = I_R_ADDR_VALID && !D_R_ADDR_VALID;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_m_r_valid <= 1'b0;
      r_m_w_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (D_W_VALID) begin
            r_state     <= S_WR_REQ;
            r_wr_addr   <= D_W_ADDR;
            r_wr_data   <= D_W_DATA;
            r_m_w_valid <= 1'b1;
          end else if (w_grant_i) begin
            r_state     <= S_RD_I;
            r_rd_addr   <= I_R_ADDR;
            r_m_r_valid <= 1'b1;
          end else if (w_grant_d) begin
            r_state     <= S_RD_D;
            r_rd_addr   <= D_R_ADDR;
            r_m_r_valid <= 1'b1;
          end
        end
        S_RD_I, S_RD_D: begin
          if (M_R_DATA_VALID) begin
            r_state     <= S_IDLE;
            r_m_r_valid <= 1'b0;
          end
        end
        S_WR_REQ: begin
          if (M_W_READY) begin
            r_state     <= S_WR_WAIT;
            r_m_w_valid <= 1'b0;
          end
        end
        S_WR_WAIT: begin
          if (M_W_COMPLETE) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_m_r_valid <= 1'b0;
          r_m_w_valid <= 1'b0;
        end
      endcase
    end
  end

  // Completions are qualified by state so stray LLC responses never reach a requester
  assign I_R_DATA       = M_R_DATA;
  assign D_R_DATA       = M_R_DATA;
  assign I_R_DATA_VALID = (r_state == S_RD_I) && M_R_DATA_VALID;
  assign D_R_DATA_VALID = (r_state == S_RD_D) && M_R_DATA_VALID;
  assign D_W_READY      = (r_state == S_WR_REQ) && M_W_READY;
  assign D_W_COMPLETE   = (r_state == S_WR_WAIT) && M_W_COMPLETE;

  assign M_R_ADDR       = r_rd_addr;
  assign M_R_ADDR_VALID = r_m_r_valid;
  assign M_W_VALID      = r_m_w_valid;
  assign M_W_ADDR       = r_wr_addr;
  assign M_W_DATA       = r_wr_data;

endmodule
`default_nettype wire

// File: doc/l1_llc_arbiter.md
# l1_llc_arbiter

Shares the single LLC request port among the three L1 miss sources: L1-I line refill, L1-D line refill, and L1-D dirty-line writeback. It sits between `L1_I`/`L1_D` and `LLC`, so the LLC needs only one read port and one write port. It serialises requests through a small FSM and routes each completion back to the requester that was granted. Policy: writeback has strict priority; the two reads are arbitrated per the configuration macro.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, address width
- `LINE_WIDTH`, 512, cache line width in bits

Ports:
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high
- `I_R_ADDR` input ADDR_WIDTH: L1-I refill line address
- `I_R_ADDR_VALID` input 1: L1-I refill request, level
- `I_R_DATA` output LINE_WIDTH: refill line to L1-I
- `I_R_DATA_VALID` output 1: one-cycle completion pulse to L1-I
- `D_R_ADDR`, `D_R_ADDR_VALID`, `D_R_DATA`, `D_R_DATA_VALID`: same as the `I_*` group, for L1-D
- `D_W_VALID` input 1: L1-D writeback request, level
- `D_W_ADDR` input ADDR_WIDTH: writeback line address
- `D_W_DATA` input LINE_WIDTH: writeback line
- `D_W_READY` output 1: writeback accepted by LLC
- `D_W_COMPLETE` output 1: one-cycle writeback-done pulse
- `M_R_ADDR` output ADDR_WIDTH, `M_R_ADDR_VALID` output 1, `M_R_DATA` input LINE_WIDTH, `M_R_DATA_VALID` input 1: LLC read port
- `M_W_VALID` output 1, `M_W_ADDR` output ADDR_WIDTH, `M_W_DATA` output LINE_WIDTH, `M_W_READY` input 1, `M_W_COMPLETE` input 1: LLC write port

## Operation
- FSM states: IDLE, RD_I, RD_D, WR_REQ, WR_WAIT. Reset state is IDLE.
- Decisions are made in IDLE, in priority order:
  - `D_W_VALID` → WR_REQ.
  - Otherwise, reads are arbitrated per Configuration → RD_I or RD_D.
  - No request → stay in IDLE.
- On entering a grant state, the arbiter latches the grantee's address (and, for a write, its data) into internal registers. `M_*_ADDR` and `M_W_DATA` are driven only from these registers.
- RD_x:
  - `M_R_ADDR_VALID`=1.
  - When `M_R_DATA_VALID` arrives, `M_R_DATA` passes combinationally to the grantee's `*_R_DATA` and its `*_R_DATA_VALID` pulses the same cycle. The other requester's DATA_VALID stays 0.
  - Next state: IDLE.
- WR_REQ:
  - `M_W_VALID`=1.
  - `M_W_READY`=1 → pulse `D_W_READY`, go to WR_WAIT.
- WR_WAIT:
  - `M_W_VALID`=0.
  - `M_W_COMPLETE` → pulse `D_W_COMPLETE`, go to IDLE.
- Writeback precedes any pending D read. This guarantees a dirty victim reaches the LLC before the refill that evicted it.
- A requester must hold its VALID until its completion. If VALID drops early, the latched transaction still completes and the pulse is still delivered.
- `M_R_DATA_VALID`/`M_W_COMPLETE` arriving outside the matching state are ignored (no pulse to any requester).

## Timing
- Reset values:
  - all `*_VALID` outputs, `D_W_READY`, `D_W_COMPLETE` = 0
  - latched address/data = 0
  - last-read-grant = D (so I wins the first contested read under RR)
- Asynchronous reset mid-transaction returns the FSM to IDLE immediately and deasserts all outputs. The LLC shares the same reset, so no stale response is expected.
- Grant latency: a request seen in IDLE at cycle N gives `M_*_VALID`=1 from cycle N+1.
- Completion: pulse in cycle K → IDLE at K+1 → next `M_*_VALID` no earlier than K+2. Exactly one bubble cycle between back-to-back transactions.
- Requester data and completion paths are combinational: zero added latency.

## Configuration
- `L1_ARB_RR_EN` defined:
  - I/D reads use round-robin on a 1-bit last-grant register, updated on every read grant.
  - When both are pending, the one not granted last wins.
- `L1_ARB_RR_EN` undefined:
  - fixed priority, D read over I read
  - no last-grant register

## Test plan
- Single I refill, addr 0x1000; LLC responds 5 cycles after grant with pattern A → `M_R_ADDR`=0x1000 from cycle 1; `I_R_DATA`=A with a 1-cycle `I_R_DATA_VALID`; `D_R_DATA_VALID` stays 0.
- `D_W_VALID` (0x2040) and `D_R_ADDR_VALID` (0x2040) asserted together → write granted first; `D_W_READY` pulse, then `D_W_COMPLETE`. `M_R_ADDR_VALID` rises only after IDLE is re-entered (bubble verified).
- I and D reads asserted together continuously for 4 transactions:
  - RR build: grants I, D, I, D
  - non-RR build: grants D×4 while I stays pending
- `reset` asserted asynchronously mid-cycle while in RD_D → `M_R_ADDR_VALID` drops before the next clock edge; FSM is in IDLE after release; no DATA_VALID pulse.
- Spurious `M_R_DATA_VALID` while in IDLE → no requester pulse; state unchanged.
- `D_R_ADDR_VALID` dropped one cycle after grant → transaction still completes; `D_R_DATA_VALID` still pulses once.
